riscv_lsu: RTL and testbench

Parametrised load/store unit for the MEM stage of the `riscv_core` pipeline. It replaces the fixed single-cycle `data_*` memory port with a request/grant/response bus that has wait states. It supports:
- byte, halfword, word and (DW=64) doubleword accesses;
- byte-lane steering with sign or zero extension;
- misalignment detection and a response timeout.

While a transaction is outstanding it stalls the pipeline through `lsu_stall_o`, which the pipeline controller ORs into all stage stalls.

---
 rtl/riscv_lsu.sv | 209 ++++++++++++++++++++
 tb/tb_riscv_lsu.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_lsu.sv
// Load/store unit for the MEM stage: request/grant/response bus, lane steering, sign/zero extension, misalign + timeout faults.
// Latency: zero-wait bus gives 3 stall cycles with the result in the 4th (DONE); each gnt/rvalid wait cycle adds one.
// Backpressure: lsu_stall_o holds the whole pipeline while a legal access is pending; bus outputs stay stable until bus_gnt_i.
module riscv_lsu #(
    parameter int DW      = 32,   // 32 or 64
    parameter int AW      = 32,
    parameter int TIMEOUT = 16    // 0 disables the timeout
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_rd_i,
    input  logic            req_wr_i,
    input  logic [2:0]      funct3_i,
    input  logic [AW-1:0]   addr_i,
    input  logic [DW-1:0]   wdata_i,
    output logic            lsu_stall_o,
    output logic [DW-1:0]   rdata_o,
    output logic            rdata_valid_o,
    output logic            misalign_o,
    output logic            fault_o,
    output logic            bus_req_o,
    output logic            bus_we_o,
    output logic [AW-1:0]   bus_addr_o,
    output logic [DW/8-1:0] bus_be_o,
    output logic [DW-1:0]   bus_wdata_o,
    input  logic            bus_gnt_i,
    input  logic            bus_rvalid_i,
    input  logic [DW-1:0]   bus_rdata_i,
    input  logic            bus_err_i
);

    localparam int BW = DW / 8;
    localparam int LB = $clog2(BW);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RESP,
        ST_DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] to_cnt;
    logic [2:0]    f3_q;
    logic [LB-1:0] lane_q;

    // Request decode (valid only while IDLE)
    logic          req_any;
    logic          illegal;
    logic          legal_req;
    logic [1:0]    size;
    logic [LB-1:0] lane;
    logic [BW-1:0] be_base;
    logic [BW-1:0] be_lane;
    logic [DW-1:0] wdata_rep;

    // Response path
    logic [DW-1:0] rsp_shift;
    logic [DW-1:0] load_ext;
    logic          in_flight;
    logic          rsp_take;
    logic          timed_out;

    assign req_any   = req_rd_i | req_wr_i;
    assign size      = funct3_i[1:0];
    assign lane      = addr_i[LB-1:0];
    assign legal_req = req_any & ~illegal;

    // Reject sizes the data path cannot carry and accesses not naturally aligned
    always_comb begin
        illegal = 1'b0;
        case (size)
            2'b01:   illegal = addr_i[0];
            2'b10:   illegal = |addr_i[1:0];
            2'b11:   illegal = (DW == 32) || (|addr_i[2:0]);
            default: illegal = 1'b0;
        endcase
        if (funct3_i == 3'b111) begin
            illegal = 1'b1;
        end
        if ((DW == 32) && (funct3_i == 3'b110)) begin
            illegal = 1'b1;
        end
    end

    // Byte-enable pattern for the access size, shifted to the addressed lane
    always_comb begin
        case (size)
            2'b00:   be_base = BW'(1);
            2'b01:   be_base = BW'(3);
            2'b10:   be_base = BW'(15);
            default: be_base = '1;
        endcase
    end

    assign be_lane = be_base << lane;

    // Replicate right-aligned store data into every lane so the enables pick the right copy
    always_comb begin
        case (size)
            2'b00:   wdata_rep = {BW{wdata_i[7:0]}};
            2'b01:   wdata_rep = {(DW/16){wdata_i[15:0]}};
            2'b10:   wdata_rep = {(DW/32){wdata_i[31:0]}};
            default: wdata_rep = wdata_i;
        endcase
    end

    assign rsp_shift = bus_rdata_i >> {lane_q, 3'b000};

    // Right-align the addressed lane and extend according to the latched funct3
    always_comb begin
        case (f3_q)
            3'b000:  load_ext = DW'($signed(rsp_shift[7:0]));
            3'b001:  load_ext = DW'($signed(rsp_shift[15:0]));
            3'b010:  load_ext = DW'($signed(rsp_shift[31:0]));
            3'b100:  load_ext = DW'(rsp_shift[7:0]);
            3'b101:  load_ext = DW'(rsp_shift[15:0]);
            3'b110:  load_ext = DW'(rsp_shift[31:0]);
            default: load_ext = rsp_shift;
        endcase
    end

    // A response only counts in RESP, or in REQ together with the grant; anything else is stale
    assign in_flight = (state == ST_REQ) || (state == ST_RESP);
    assign rsp_take  = ((state == ST_REQ) && bus_gnt_i && bus_rvalid_i) ||
                       ((state == ST_RESP) && bus_rvalid_i);
    assign timed_out = (TIMEOUT != 0) && in_flight && !rsp_take && (to_cnt == TO_LAST);

    // Stall is combinational in IDLE so the pipeline freezes in the very cycle the access appears
    assign lsu_stall_o = ((state == ST_IDLE) && legal_req) || in_flight;
    assign misalign_o  = (state == ST_IDLE) && req_any && illegal;

    // Transaction FSM with registered bus outputs and result/fault pulses
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= ST_IDLE;
            to_cnt        <= '0;
            f3_q          <= '0;
            lane_q        <= '0;
            rdata_o       <= '0;
            rdata_valid_o <= 1'b0;
            fault_o       <= 1'b0;
            bus_req_o     <= 1'b0;
            bus_we_o      <= 1'b0;
            bus_addr_o    <= '0;
            bus_be_o      <= '0;
            bus_wdata_o   <= '0;
        end else begin
            rdata_valid_o <= 1'b0;
            fault_o       <= 1'b0;

            if (in_flight) begin
                to_cnt <= to_cnt + 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (legal_req) begin
                        state       <= ST_REQ;
                        to_cnt      <= '0;
                        f3_q        <= funct3_i;
                        lane_q      <= lane;
                        bus_req_o   <= 1'b1;
                        bus_we_o    <= req_wr_i;
                        bus_addr_o  <= {addr_i[AW-1:LB], {LB{1'b0}}};
                        bus_be_o    <= be_lane;
                        bus_wdata_o <= wdata_rep;
                    end
                end
                ST_REQ: begin
                    // Completion beats the timeout in the last allowed cycle; a lone grant does not
                    if (rsp_take || timed_out) begin
                        state     <= ST_DONE;
                        bus_req_o <= 1'b0;
                    end else if (bus_gnt_i) begin
                        state     <= ST_RESP;
                        bus_req_o <= 1'b0;
                    end
                end
                ST_RESP: begin
                    if (rsp_take || timed_out) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Request inputs are ignored here; the pipeline advances on this edge
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase

            if (rsp_take) begin
                if (bus_err_i) begin
                    fault_o <= 1'b1;
                end else if (!bus_we_o) begin
                    rdata_o       <= load_ext;
                    rdata_valid_o <= 1'b1;
                end
            end else if (timed_out) begin
                fault_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_riscv_lsu.sv
// Bench for riscv_lsu: a 32-bit unit (TIMEOUT=4) and a 64-bit unit (TIMEOUT=16) share one stimulus path.
// Each access is played through a small bus responder; expected pulses go into a scoreboard queue.
// A negedge monitor pops the queue whenever the selected unit emits rdata_valid_o or fault_o.
module tb_riscv_lsu;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        sel;           // 0: 32-bit unit, 1: 64-bit unit
    logic        req_rd, req_wr;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic        gnt, rvalid, err;
    logic [63:0] rdata;

    logic        a_stall, a_rv, a_mis, a_flt, a_req, a_we;
    logic [31:0] a_rdata, a_addr, a_wdata;
    logic [3:0]  a_be;
    logic        b_stall, b_rv, b_mis, b_flt, b_req, b_we;
    logic [63:0] b_rdata, b_wdata;
    logic [31:0] b_addr;
    logic [7:0]  b_be;

    riscv_lsu #(.DW(32), .AW(32), .TIMEOUT(4)) u_lsu32 (
        .clk_i(clk), .rst_i(rst),
        .req_rd_i(req_rd & ~sel), .req_wr_i(req_wr & ~sel),
        .funct3_i(funct3), .addr_i(addr), .wdata_i(wdata[31:0]),
        .lsu_stall_o(a_stall), .rdata_o(a_rdata), .rdata_valid_o(a_rv),
        .misalign_o(a_mis), .fault_o(a_flt),
        .bus_req_o(a_req), .bus_we_o(a_we), .bus_addr_o(a_addr),
        .bus_be_o(a_be), .bus_wdata_o(a_wdata),
        .bus_gnt_i(gnt & ~sel), .bus_rvalid_i(rvalid & ~sel),
        .bus_rdata_i(rdata[31:0]), .bus_err_i(err & ~sel)
    );

    riscv_lsu #(.DW(64), .AW(32), .TIMEOUT(16)) u_lsu64 (
        .clk_i(clk), .rst_i(rst),
        .req_rd_i(req_rd & sel), .req_wr_i(req_wr & sel),
        .funct3_i(funct3), .addr_i(addr), .wdata_i(wdata),
        .lsu_stall_o(b_stall), .rdata_o(b_rdata), .rdata_valid_o(b_rv),
        .misalign_o(b_mis), .fault_o(b_flt),
        .bus_req_o(b_req), .bus_we_o(b_we), .bus_addr_o(b_addr),
        .bus_be_o(b_be), .bus_wdata_o(b_wdata),
        .bus_gnt_i(gnt & sel), .bus_rvalid_i(rvalid & sel),
        .bus_rdata_i(rdata), .bus_err_i(err & sel)
    );

    // Outputs of the currently selected unit, widened to 64 bits
    logic [63:0] o_stall, o_rv, o_mis, o_flt, o_req, o_we, o_addr, o_be, o_wdata, o_rdata;
    always_comb begin
        o_stall = 64'(sel ? b_stall : a_stall);
        o_rv    = 64'(sel ? b_rv    : a_rv);
        o_mis   = 64'(sel ? b_mis   : a_mis);
        o_flt   = 64'(sel ? b_flt   : a_flt);
        o_req   = 64'(sel ? b_req   : a_req);
        o_we    = 64'(sel ? b_we    : a_we);
        o_addr  = 64'(sel ? b_addr  : a_addr);
        o_be    = sel ? 64'(b_be)    : 64'(a_be);
        o_wdata = sel ? b_wdata      : 64'(a_wdata);
        o_rdata = sel ? b_rdata      : 64'(a_rdata);
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    typedef struct {
        bit          flt;
        logic [63:0] data;
    } exp_t;

    typedef struct {
        bit          sel;
        bit          we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        bit          err;
        int          gw;     // grant wait cycles in REQ
        int          rw;     // extra cycles between grant and rvalid
        bit          tog;    // rvalid together with grant
        bit          flt;    // fault expected (bus error or timeout)
        logic [63:0] be;
        logic [63:0] bwd;    // expected bus_wdata_o for stores
        logic [63:0] res;    // expected rdata_o for loads
        int          stall;  // expected stall cycles
    } vec_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    vec_t        vq[$];
    logic [63:0] last_good_a = 64'h0;

    // Scoreboard: every result/fault pulse must match the next expected entry
    always @(negedge clk) begin
        if (o_rv[0] || o_flt[0]) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected", {62'b0, o_rv[0], o_flt[0]}, 64'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("sb_kind", {62'b0, o_rv[0], o_flt[0]}, mon_e.flt ? 64'd1 : 64'd2);
                if (!mon_e.flt) begin
                    check("sb_rdata", o_rdata, mon_e.data);
                end
            end
        end
    end

    // Called just after a rising edge; returns just after a rising edge
    task automatic do_access(input vec_t v);
        logic [63:0] exp_addr;
        int          n_stall;
        bit          done;
        exp_t        e;
        exp_addr = 64'(v.addr & (v.sel ? 32'hFFFF_FFF8 : 32'hFFFF_FFFC));
        sel = v.sel; req_rd = !v.we; req_wr = v.we; funct3 = v.f3; addr = v.addr; wdata = v.wdata;
        gnt = 1'b0; rvalid = 1'b0; err = 1'b0; rdata = 64'h0;
        if (v.flt || !v.we) begin
            e.flt  = v.flt;
            e.data = v.res;
            sb_q.push_back(e);
            if (!v.flt && !v.sel) last_good_a = v.res;
        end
        @(negedge clk);
        check("idle_stall", o_stall, 1);
        check("idle_mis", o_mis, 0);
        check("idle_req", o_req, 0);
        n_stall = 1;
        done    = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(posedge clk); #1;
            gnt    = (c == v.gw);
            rvalid = v.tog ? (c == v.gw) : (c == v.gw + 1 + v.rw);
            err    = rvalid & v.err;
            rdata  = rvalid ? v.rdata : 64'h0;
            @(negedge clk);
            if (!o_stall[0]) begin
                done = 1'b1;
                check("done_req", o_req, 0);
            end else begin
                n_stall++;
                if (c <= v.gw) begin
                    check("req_req", o_req, 1);
                    check("req_addr", o_addr, exp_addr);
                    check("req_be", o_be, v.be);
                    check("req_we", o_we, 64'(v.we));
                    if (v.we) check("req_wdata", o_wdata, v.bwd);
                end else begin
                    check("resp_req", o_req, 0);
                end
            end
        end
        check("done_seen", 64'(done), 1);
        check("stall_cycles", 64'(n_stall), 64'(v.stall));
        @(posedge clk); #1;
        req_rd = 1'b0; req_wr = 1'b0; gnt = 1'b0; rvalid = 1'b0; err = 1'b0; rdata = 64'h0;
    endtask

    task automatic do_misalign(input bit s, input bit we, input logic [2:0] f3, input logic [31:0] a);
        sel = s; req_rd = !we; req_wr = we; funct3 = f3; addr = a; wdata = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        check("mis_pulse", o_mis, 1);
        check("mis_stall", o_stall, 0);
        @(posedge clk); #1;
        req_rd = 1'b0; req_wr = 1'b0;
        @(negedge clk);
        check("mis_req", o_req, 0);
        check("mis_clear", o_mis, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; sel = 1'b0; req_rd = 1'b0; req_wr = 1'b0; funct3 = 3'b0; addr = 32'h0;
        wdata = 64'h0; gnt = 1'b0; rvalid = 1'b0; err = 1'b0; rdata = 64'h0;

        //            sel we  f3      addr      wdata                   rdata                   err gw  rw  tog flt be      bwd                     res                     stall
        vq.push_back('{0, 0, 3'b000, 32'h103, 64'h0,                  64'h80FF_FFFF,          0,  0,  0,  0,  0,  64'h08, 64'h0,                  64'hFFFF_FF80,          3});
        vq.push_back('{0, 1, 3'b001, 32'h202, 64'h1234_ABCD,          64'h0,                  0,  1,  0,  0,  0,  64'h0C, 64'hABCD_ABCD,          64'h0,                  4});
        vq.push_back('{0, 0, 3'b100, 32'h101, 64'h0,                  64'h1234_5678,          0,  0,  0,  1,  0,  64'h02, 64'h0,                  64'h56,                 2});
        vq.push_back('{0, 0, 3'b001, 32'h002, 64'h0,                  64'h8001_0000,          0,  0,  2,  0,  0,  64'h0C, 64'h0,                  64'hFFFF_8001,          5});
        vq.push_back('{0, 0, 3'b101, 32'h002, 64'h0,                  64'h8001_0000,          0,  0,  0,  0,  0,  64'h0C, 64'h0,                  64'h8001,               3});
        vq.push_back('{0, 0, 3'b010, 32'h010, 64'h0,                  64'hDEAD_BEEF,          0,  1,  1,  0,  0,  64'h0F, 64'h0,                  64'hDEAD_BEEF,          5});
        vq.push_back('{0, 1, 3'b000, 32'h003, 64'hA5,                 64'h0,                  0,  0,  0,  0,  0,  64'h08, 64'hA5A5_A5A5,          64'h0,                  3});
        vq.push_back('{0, 1, 3'b010, 32'h004, 64'hCAFE_F00D,          64'h0,                  0,  0,  0,  1,  0,  64'h0F, 64'hCAFE_F00D,          64'h0,                  2});
        vq.push_back('{0, 0, 3'b010, 32'h020, 64'h0,                  64'h1111_1111,          1,  0,  0,  0,  1,  64'h0F, 64'h0,                  64'h0,                  3});
        vq.push_back('{0, 1, 3'b010, 32'h024, 64'h55,                 64'h0,                  1,  0,  0,  0,  1,  64'h0F, 64'h55,                 64'h0,                  3});
        vq.push_back('{0, 0, 3'b010, 32'h040, 64'h0,                  64'h0,                  0,  99, 0,  0,  1,  64'h0F, 64'h0,                  64'h0,                  5});
        vq.push_back('{0, 0, 3'b000, 32'h041, 64'h0,                  64'h0,                  0,  0,  99, 0,  1,  64'h02, 64'h0,                  64'h0,                  5});
        vq.push_back('{1, 0, 3'b110, 32'h00C, 64'h0,                  64'h8765_4321_0000_0000, 0, 0,  0,  0,  0,  64'hF0, 64'h0,                  64'h0000_0000_8765_4321, 3});
        vq.push_back('{1, 0, 3'b011, 32'h008, 64'h0,                  64'h0123_4567_89AB_CDEF, 0, 0,  0,  1,  0,  64'hFF, 64'h0,                  64'h0123_4567_89AB_CDEF, 2});
        vq.push_back('{1, 0, 3'b010, 32'h004, 64'h0,                  64'h8000_0000_0000_0000, 0, 2,  0,  0,  0,  64'hF0, 64'h0,                  64'hFFFF_FFFF_8000_0000, 5});
        vq.push_back('{1, 1, 3'b011, 32'h010, 64'h1122_3344_5566_7788, 64'h0,                 0,  0,  0,  0,  0,  64'hFF, 64'h1122_3344_5566_7788, 64'h0,                 3});
        vq.push_back('{1, 1, 3'b000, 32'h005, 64'h7E,                 64'h0,                  0,  0,  0,  0,  0,  64'h20, 64'h7E7E_7E7E_7E7E_7E7E, 64'h0,                 3});
        vq.push_back('{1, 1, 3'b001, 32'h006, 64'hBEEF,               64'h0,                  0,  0,  1,  0,  0,  64'hC0, 64'hBEEF_BEEF_BEEF_BEEF, 64'h0,                 4});
        vq.push_back('{1, 1, 3'b010, 32'h00C, 64'h89AB_CDEF,          64'h0,                  0,  0,  0,  0,  0,  64'hF0, 64'h89AB_CDEF_89AB_CDEF, 64'h0,                 3});
        vq.push_back('{1, 0, 3'b000, 32'h007, 64'h0,                  64'h7F00_0000_0000_0000, 0, 0,  0,  0,  0,  64'h80, 64'h0,                  64'h7F,                 3});

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_a_ctl", 64'({a_stall, a_rv, a_mis, a_flt, a_req, a_we, a_be}), 0);
        check("rst_a_addr", 64'(a_addr), 0);
        check("rst_a_wdata", 64'(a_wdata), 0);
        check("rst_a_rdata", 64'(a_rdata), 0);
        check("rst_b_ctl", 64'({b_stall, b_rv, b_mis, b_flt, b_req, b_we, b_be}), 0);
        check("rst_b_addr", 64'(b_addr), 0);
        check("rst_b_wdata", b_wdata, 0);
        check("rst_b_rdata", b_rdata, 0);
        @(posedge clk); #1;

        // 32-bit unit: normal traffic, bus errors, timeout without grant
        for (int i = 0; i <= 10; i++) do_access(vq[i]);

        // A response arriving after the timeout abort must be ignored
        sel = 1'b0; rvalid = 1'b1; rdata = 64'hFFFF_FFFF;
        @(negedge clk);
        check("late_rvalid", {62'b0, o_rv[0], o_flt[0]}, 0);
        @(posedge clk); #1;
        rvalid = 1'b0; rdata = 64'h0;

        do_access(vq[11]);
        check("rdata_hold", 64'(a_rdata), last_good_a);

        do_misalign(0, 0, 3'b010, 32'h001);
        do_misalign(0, 0, 3'b001, 32'h003);
        do_misalign(0, 0, 3'b011, 32'h000);
        do_misalign(0, 0, 3'b110, 32'h000);
        do_misalign(0, 0, 3'b111, 32'h000);
        do_misalign(0, 1, 3'b010, 32'h002);

        // 64-bit unit
        for (int i = 12; i < 20; i++) do_access(vq[i]);
        do_misalign(1, 0, 3'b011, 32'h004);
        do_misalign(1, 0, 3'b111, 32'h000);
        do_misalign(1, 1, 3'b001, 32'h001);

        // Reset while the 32-bit unit waits in RESP
        sel = 1'b0; req_rd = 1'b1; funct3 = 3'b010; addr = 32'h080;
        @(posedge clk); #1;
        gnt = 1'b1;
        @(posedge clk); #1;
        gnt = 1'b0; rst = 1'b1;
        @(negedge clk);
        check("rst_resp_stall", o_stall, 1);
        @(posedge clk); #1;
        rst = 1'b0; req_rd = 1'b0; rvalid = 1'b1; rdata = 64'h1234_5678;
        @(negedge clk);
        check("rstm_ctl", 64'({a_stall, a_rv, a_mis, a_flt, a_req, a_we, a_be}), 0);
        check("rstm_addr", 64'(a_addr), 0);
        check("rstm_wdata", 64'(a_wdata), 0);
        check("rstm_rdata", 64'(a_rdata), 0);
        @(posedge clk); #1;
        rvalid = 1'b0; rdata = 64'h0;
        @(negedge clk);
        check("rstm_nopulse", {62'b0, o_rv[0], o_flt[0]}, 0);
        check("rstm_rdata2", 64'(a_rdata), 0);

        check("sb_empty", 64'(sb_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
